fixed_point_adder_pipe: RTL and testbench
=========================================

// Module: fixed_point_adder_pipe
// PURPOSE
//  Pipelined synchronous add/subtract of two signed fixed-point operands.
//  Operand formats are independent. Output is in format C, with selectable rounding
//  and saturation, and a per-sample overflow flag.
//  It is the clocked successor of the asynchronous adder and the accumulate/tap-sum
//  stage of the FIR datapath. Valid/ready flow control on both sides.
// PARAMETERS
//  A_FRAC_LEN  2  fractional bits of a
//  A_WORD_LEN  4  total bits of a (signed two's complement)
//  B_FRAC_LEN  3  fractional bits of b
//  B_WORD_LEN  7  total bits of b
//  C_FRAC_LEN  2  fractional bits of c
//  C_WORD_LEN  7  total bits of c
//  ROUND_MODE  0  0 = truncate (floor); 1 = round half up (toward +inf)
//  SATURATE    1  1 = clamp to C range on overflow; 0 = wrap (keep low C_WORD_LEN bits)
// PORTS
//  clk        in   1           single clock, all state on rising edge
//  rst_n      in   1           synchronous active-low reset
//  in_valid   in   1           a/b/op_sub valid
//  in_ready   out  1           block can accept a sample this cycle
//  a          in   A_WORD_LEN  signed operand a
//  b          in   B_WORD_LEN  signed operand b
//  op_sub     in   1           0: c=a+b, 1: c=a-b
//  out_valid  out  1           c/ovf valid
//  out_ready  in   1           downstream accepts c this cycle
//  c          out  C_WORD_LEN  signed result
//  ovf        out  1           result exceeded C range (clamped or wrapped)
// BEHAVIOUR
//  - Reset: on a clk edge with rst_n=0, both stage valids, c and ovf clear to 0.
//    Inputs presented while rst_n=0 are dropped. In-flight samples are discarded.
//  - Transfer: an input is accepted on an edge with in_valid&in_ready. An output is
//    consumed on an edge with out_valid&out_ready.
//  - Pipeline: two register stages S1 and S2. S2 drives c/ovf/out_valid directly.
//    adv2 = !s2_valid | out_ready.  adv1 = !s1_valid | adv2.  in_ready = adv1.
//    in_ready is combinational from state and out_ready. It never depends on in_valid.
//  - Latency: 2 cycles accept->out_valid when unstalled. Full throughput of 1 sample/cycle.
//  - Under stall, c/ovf/out_valid hold stable until consumed. Order is preserved.
//    The pipeline holds at most 2 samples.
//  - S1, exact sum:
//    F = max(A_FRAC_LEN,B_FRAC_LEN); I = max(A_WORD_LEN-A_FRAC_LEN, B_WORD_LEN-B_FRAC_LEN).
//    Sign-extend and left-shift both operands to an I+F+1 bit width.
//    Add, or subtract when op_sub=1. No loss occurs in this stage.
//  - S2, format conversion:
//    - C_FRAC_LEN>=F: left-shift by C_FRAC_LEN-F.
//    - Otherwise drop D=F-C_FRAC_LEN LSBs by arithmetic shift.
//    - ROUND_MODE=1: add 2^(D-1) before the shift. Use one guard bit so the rounding
//      increment itself cannot wrap.
//    - Range check against [-2^(C_WORD_LEN-1), 2^(C_WORD_LEN-1)-1] LSBs of C.
//    - Out of range: ovf=1. c = max/min when SATURATE=1, else the low C_WORD_LEN bits.
//    - ovf is meaningful only while out_valid=1.
//  - Simultaneous accept and consume with both stages full: both stages shift.
//    No bubble and no loss.
// TESTING (defaults unless stated; a Q2.2, b Q4.3, c Q5.2)
//  1 a=4'b0110(1.5), b=7'b0001100(1.5), op_sub=0, out_ready=1
//    -> 2 cycles later c=7'd12(3.0), ovf=0, out_valid=1 for exactly 1 cycle.
//  2 a=0, b=7'b0000001(0.125): ROUND_MODE=0 -> c=0; ROUND_MODE=1 -> c=1(0.25).
//    b=7'b1111111(-0.125): ROUND_MODE=0 -> c=7'h7F(-0.25); ROUND_MODE=1 -> c=0.
//  3 Subtract: a=4'b0111(1.75), b=7'b1000000(-8.0), op_sub=1 -> c=7'd39(9.75), ovf=0.
//  4 C_WORD_LEN=5, a=1.5, b=3.0 (sum 4.5):
//    SATURATE=1 -> c=5'b01111, ovf=1; SATURATE=0 -> c=5'b10010, ovf=1.
//    Negative case a=-2.0, b=-3.0 with SATURATE=1 -> c=5'b10000, ovf=1.
//  5 Backpressure: out_ready=0, stream 4 samples with in_valid=1.
//    -> exactly 2 accepted, then in_ready=0 and c stable.
//    Raise out_ready -> all accepted samples delivered in order; none duplicated or lost.
//  6 Reset mid-operation: 2 samples in flight, rst_n=0 for 1 edge
//    -> out_valid=0, c=0, ovf=0, in_ready=1 after release.
//    Inputs offered during reset never appear at the output.
//  Bench: random a/b/op_sub/out_ready vs a real-arithmetic reference model;
//  checker asserts c stable while out_valid&!out_ready.

Source files
------------

// File: rtl/fixed_point_adder_pipe.sv
// Two-stage pipelined signed fixed-point add/subtract with valid/ready flow control.
// S1 forms the exact sum on a common binary point; S2 converts it to the C format
// with optional round-half-up and saturation, and drives c/ovf/out_valid directly.
module fixed_point_adder_pipe #(
    parameter int A_FRAC_LEN = 2,
    parameter int A_WORD_LEN = 4,
    parameter int B_FRAC_LEN = 3,
    parameter int B_WORD_LEN = 7,
    parameter int C_FRAC_LEN = 2,
    parameter int C_WORD_LEN = 7,
    parameter int ROUND_MODE = 0,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [A_WORD_LEN-1:0] a,
    input  logic [B_WORD_LEN-1:0] b,
    input  logic                  op_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [C_WORD_LEN-1:0] c,
    output logic                  ovf
);
    // Common binary point for the exact sum: widest fraction, widest integer part,
    // plus one bit so the add/subtract can never overflow.
    localparam int F  = (A_FRAC_LEN > B_FRAC_LEN) ? A_FRAC_LEN : B_FRAC_LEN;
    localparam int AI = A_WORD_LEN - A_FRAC_LEN;
    localparam int BI = B_WORD_LEN - B_FRAC_LEN;
    localparam int I  = (AI > BI) ? AI : BI;
    localparam int SW = I + F + 1;

    // Conversion shifts: exactly one of these is nonzero (or both zero).
    localparam int LSH    = (C_FRAC_LEN >= F) ? C_FRAC_LEN - F : 0;
    localparam int RSH    = (C_FRAC_LEN >= F) ? 0 : F - C_FRAC_LEN;
    localparam int RND_SH = (RSH > 0) ? RSH - 1 : 0;

    // Working width keeps headroom above both the shifted sum and the C range, so the
    // rounding increment and the range compare never wrap.
    localparam int WW = SW + LSH + C_WORD_LEN + 2;

    localparam logic signed [WW-1:0] RND  =
        {{(WW-1){1'b0}}, (ROUND_MODE != 0) && (RSH > 0)} << RND_SH;
    localparam logic signed [WW-1:0] CMAX =
        {{(WW-C_WORD_LEN+1){1'b0}}, {(C_WORD_LEN-1){1'b1}}};
    localparam logic signed [WW-1:0] CMIN =
        {{(WW-C_WORD_LEN+1){1'b1}}, {(C_WORD_LEN-1){1'b0}}};

    logic                  s1_valid, s2_valid;
    logic signed [SW-1:0]  s1_sum;
    logic                  adv1, adv2;

    logic signed [SW-1:0]  a_al, b_al, sum_d;
    logic signed [WW-1:0]  ext, conv;
    logic                  ovf_d;
    logic [C_WORD_LEN-1:0] c_d;

    // Handshake: a stage may load when it is empty or its contents move on.
    always_comb begin
        adv2     = !s2_valid || out_ready;
        adv1     = !s1_valid || adv2;
        in_ready = adv1;
    end

    assign out_valid = s2_valid;

    // S1 datapath: align both operands to F fractional bits and add/subtract exactly.
    always_comb begin
        a_al  = $signed({{(SW-A_WORD_LEN){a[A_WORD_LEN-1]}}, a}) <<< (F - A_FRAC_LEN);
        b_al  = $signed({{(SW-B_WORD_LEN){b[B_WORD_LEN-1]}}, b}) <<< (F - B_FRAC_LEN);
        sum_d = op_sub ? (a_al - b_al) : (a_al + b_al);
    end

    // S2 datapath: rescale to C, optional round-half-up, then range check and clamp/wrap.
    always_comb begin
        ext   = {{(WW-SW){s1_sum[SW-1]}}, s1_sum};
        conv  = ((ext <<< LSH) + RND) >>> RSH;
        ovf_d = (conv > CMAX) || (conv < CMIN);
        c_d   = conv[C_WORD_LEN-1:0];
        if (ovf_d && (SATURATE != 0))
            c_d = conv[WW-1] ? {1'b1, {(C_WORD_LEN-1){1'b0}}}
                             : {1'b0, {(C_WORD_LEN-1){1'b1}}};
    end

    // Pipeline registers; reset drops everything in flight and clears the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_sum   <= '0;
            c        <= '0;
            ovf      <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) s1_sum <= sum_d;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    c   <= c_d;
                    ovf <= ovf_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_adder_pipe.sv
// Bench for fixed_point_adder_pipe: four parameterisations driven in lockstep,
// a real-arithmetic reference model feeding a scoreboard queue, directed steps
// followed by random traffic with random backpressure.
module tb_fixed_point_adder_pipe;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, op_sub, out_ready;
    logic [3:0] a;
    logic [6:0] b;

    logic       in_ready, out_valid, ovf0, ovf1, ovf2, ovf3;
    logic       rdy1, rdy2, rdy3, v1, v2, v3;
    logic [6:0] c0, c1;
    logic [4:0] c2, c3;

    typedef struct {
        int c0, c1, c2, c3;
        bit o0, o1, o2, o3;
    } exp_t;

    exp_t q[$];
    int   ichecks = 0, ierrs = 0, mchecks = 0, merrs = 0;

    always #5 clk = ~clk;

    fixed_point_adder_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .c(c0), .ovf(ovf0));
    fixed_point_adder_pipe #(.ROUND_MODE(1)) u_rnd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(v1), .out_ready(out_ready),
        .c(c1), .ovf(ovf1));
    fixed_point_adder_pipe #(.C_WORD_LEN(5)) u_sat5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(v2), .out_ready(out_ready),
        .c(c2), .ovf(ovf2));
    fixed_point_adder_pipe #(.C_WORD_LEN(5), .SATURATE(0)) u_wrp5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(v3), .out_ready(out_ready),
        .c(c3), .ovf(ovf3));

    // Reference conversion of a real value (units of 1.0) into a Q(cw-2).2 result.
    task automatic conv(input real x, input int rm, input int cw, input bit sat,
                        output int cv, output bit o);
        real s, r;
        int  ri, hi, lo;
        s  = x * 4.0;
        r  = (rm != 0) ? $floor(s + 0.5) : $floor(s);
        ri = $rtoi(r);
        hi = (1 << (cw - 1)) - 1;
        lo = -(1 << (cw - 1));
        o  = (ri > hi) || (ri < lo);
        if (o && sat) ri = (ri > hi) ? hi : lo;
        cv = ri & ((1 << cw) - 1);
    endtask

    task automatic model(input logic [3:0] av, input logic [6:0] bv, input bit sub,
                         output exp_t e);
        real x, xa, xb;
        xa = $itor($signed(av)) / 4.0;
        xb = $itor($signed(bv)) / 8.0;
        x  = sub ? xa - xb : xa + xb;
        conv(x, 0, 7, 1'b1, e.c0, e.o0);
        conv(x, 1, 7, 1'b1, e.c1, e.o1);
        conv(x, 0, 5, 1'b1, e.c2, e.o2);
        conv(x, 0, 5, 1'b0, e.c3, e.o3);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        ichecks++;
        assert (got === exp) else begin
            ierrs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at posedge+1, decide acceptance at negedge, return at posedge+1.
    task automatic cyc(input bit iv, input logic [3:0] av, input logic [6:0] bv,
                       input bit sub, input bit ordy, output bit acc);
        exp_t e;
        in_valid  = iv;
        a         = av;
        b         = bv;
        op_sub    = sub;
        out_ready = ordy;
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
        if (acc) begin
            model(av, bv, sub, e);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] av, input logic [6:0] bv, input bit sub);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cyc(1'b1, av, bv, sub, out_ready, acc);
        chk("send_accept", int'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int k = 0; k < n; k++) cyc(1'b0, 4'd0, 7'd0, 1'b0, ordy, acc);
    endtask

    // Output monitor: scoreboard pop on consume, stability check while stalled.
    initial begin : mon
        exp_t       e;
        bit         stalled = 1'b0;
        logic [6:0] pc;
        logic       po;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    mchecks++;
                    assert (out_valid === 1'b1 && c0 === pc && ovf0 === po) else begin
                        merrs++;
                        $error("FAIL stall_hold: got v=%b c=%0h o=%b expected v=1 c=%0h o=%b",
                               out_valid, c0, ovf0, pc, po);
                    end
                end
                if (out_valid && out_ready) begin
                    mchecks++;
                    assert (q.size() > 0) else begin
                        merrs++;
                        $error("FAIL unexpected_out: got c=%0h expected no output", c0);
                    end
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        mchecks += 5;
                        assert ({rdy1, rdy2, rdy3, v1, v2, v3} === {{3{in_ready}}, {3{out_valid}}})
                        else begin
                            merrs++;
                            $error("FAIL lockstep: got %b expected %b",
                                   {rdy1, rdy2, rdy3, v1, v2, v3},
                                   {{3{in_ready}}, {3{out_valid}}});
                        end
                        assert ({25'd0, c0} === e.c0 && ovf0 === e.o0) else begin
                            merrs++;
                            $error("FAIL c_trunc: got %0h/%b expected %0h/%b", c0, ovf0, e.c0, e.o0);
                        end
                        assert ({25'd0, c1} === e.c1 && ovf1 === e.o1) else begin
                            merrs++;
                            $error("FAIL c_round: got %0h/%b expected %0h/%b", c1, ovf1, e.c1, e.o1);
                        end
                        assert ({27'd0, c2} === e.c2 && ovf2 === e.o2) else begin
                            merrs++;
                            $error("FAIL c_sat5: got %0h/%b expected %0h/%b", c2, ovf2, e.c2, e.o2);
                        end
                        assert ({27'd0, c3} === e.c3 && ovf3 === e.o3) else begin
                            merrs++;
                            $error("FAIL c_wrap5: got %0h/%b expected %0h/%b", c3, ovf3, e.c3, e.o3);
                        end
                    end
                end
                stalled = out_valid && !out_ready;
                pc      = c0;
                po      = ovf0;
            end
        end
    end

    initial begin : drv
        bit acc;
        int n;
        logic [3:0] k4;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_c", int'(c0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // 1: basic add, latency and single-cycle valid
        out_ready = 1'b1;
        send(4'b0110, 7'b0001100, 1'b0);
        @(negedge clk); chk("t1_lat1", int'(out_valid), 0);
        @(negedge clk); chk("t1_lat2", int'(out_valid), 1);
        chk("t1_c", int'(c0), 12);
        chk("t1_ovf", int'(ovf0), 0);
        @(negedge clk); chk("t1_once", int'(out_valid), 0);
        @(posedge clk); #1;

        // 2: rounding of +/-0.125
        send(4'd0, 7'b0000001, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("t2_trunc_pos", int'(c0), 0);
        chk("t2_round_pos", int'(c1), 1);
        @(posedge clk); #1;
        send(4'd0, 7'b1111111, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("t2_trunc_neg", int'(c0), 7'h7F);
        chk("t2_round_neg", int'(c1), 0);
        @(posedge clk); #1;

        // 3: subtract
        send(4'b0111, 7'b1000000, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("t3_c", int'(c0), 39);
        chk("t3_ovf", int'(ovf0), 0);
        @(posedge clk); #1;

        // 4: overflow in the 5-bit result configurations
        send(4'b0110, 7'b0011000, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("t4_sat_c", int'(c2), 5'b01111);
        chk("t4_sat_ovf", int'(ovf2), 1);
        chk("t4_wrap_c", int'(c3), 5'b10010);
        chk("t4_wrap_ovf", int'(ovf3), 1);
        @(posedge clk); #1;
        send(4'b1000, 7'b1101000, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("t4_satneg_c", int'(c2), 5'b10000);
        chk("t4_satneg_ovf", int'(ovf2), 1);
        @(posedge clk); #1;
        idle(2, 1'b1);

        // 5: backpressure, only two samples fit
        n = 0;
        for (int k = 0; k < 4; k++) begin
            k4 = 4'(n + 1);
            cyc(1'b1, k4, 7'(8 * (n + 1)), 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        in_valid = 1'b0;
        chk("t5_accepted", n, 2);
        chk("t5_in_ready", int'(in_ready), 0);
        idle(4, 1'b1);
        chk("t5_drained", q.size(), 0);

        // 6: reset with two samples in flight and an input offered during reset
        out_ready = 1'b0;
        send(4'd3, 7'd5, 1'b0);
        send(4'd5, 7'd9, 1'b1);
        rst_n = 1'b0; in_valid = 1'b1; a = 4'd7; b = 7'd33;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_c", int'(c0), 0);
        chk("t6_ovf", int'(ovf0), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        idle(5, 1'b1);

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 7, acc);
        idle(6, 1'b1);
        chk("rand_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", ichecks + mchecks, ierrs + merrs);
        $finish;
    end
endmodule
